// File: rtl/wave_pkg.sv
// Shared state encoding and size defaults for the waveform capture controller.
package wave_pkg;

  localparam int WAVE_DW        = 10;
  localparam int WAVE_FRAME_LEN = 640;
  localparam int FLUSH_CYCLES   = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FLUSH     = 3'd1,
    WAIT_TRIG = 3'd2,
    CAPTURE   = 3'd3,
    DONE      = 3'd4
  } wave_state_t;

endpackage

// File: rtl/wave_trig_det.sv
// Level-crossing trigger detector with hysteresis arming for rising or falling edges.
module wave_trig_det #(
  parameter int DW   = 10,
  parameter int HYST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          sample_ok,
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] level,
  input  logic          trig_edge,
  output logic          hit
);

  localparam int          DW1      = DW + 1;
  localparam logic [DW:0] HYST_EXT = DW1'(HYST);

  logic [DW:0]   level_ext;
  logic [DW:0]   hi_sum;
  logic [DW-1:0] arm_lo;
  logic [DW-1:0] arm_hi;
  logic          arm_cond;
  logic          armed;

  // Arm thresholds saturate at the code range ends so extreme levels still arm.
  always_comb begin
    level_ext = {1'b0, level};
    hi_sum    = level_ext + HYST_EXT;
    arm_lo    = (level_ext >= HYST_EXT) ? (level - HYST_EXT[DW-1:0]) : '0;
    arm_hi    = hi_sum[DW] ? '1 : hi_sum[DW-1:0];
    arm_cond  = trig_edge ? (sample >= arm_hi) : (sample <= arm_lo);
    hit       = armed && (trig_edge ? (sample <= level) : (sample >= level));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (clear) begin
      armed <= 1'b0;
    end else if (sample_ok && arm_cond) begin
      armed <= 1'b1;
    end
  end

endmodule

// File: rtl/wave_capture_ctrl.sv
// Frame capture controller: decimates ADC samples, waits for a trigger and
// writes one fixed-length frame into the FIFO write port.
module wave_capture_ctrl
  import wave_pkg::*;
#(
  parameter int          DW        = WAVE_DW,
  parameter int          FRAME_LEN = WAVE_FRAME_LEN,
  parameter int          HYST      = 8,
  parameter logic [23:0] AUTO_TO   = 24'd5_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          rearm,
  input  logic          auto_en,
  input  logic [15:0]   decim,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_edge,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  input  logic          fifo_full,
  output logic          fifo_we,
  output logic [DW-1:0] fifo_di,
  output logic          fifo_rst,
  output logic          frame_done,
  output logic          auto_trig,
  output logic          ovf
);

  localparam int             FCW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FCW-1:0] LAST_WORD  = FCW'(FRAME_LEN - 1);
  localparam logic [1:0]     FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  wave_state_t    state;
  wave_state_t    next_state;
  logic [15:0]    decim_q;
  logic [15:0]    dec_cnt;
  logic [FCW-1:0] frame_cnt;
  logic [1:0]     flush_cnt;
  logic [23:0]    to_cnt;

  logic in_flush, in_wait, in_capture, sampling;
  logic accept, trig_hit, trig_event, take_word, last_word, write_ok;
  logic enter_flush, enter_done;

  wave_trig_det #(
    .DW   (DW),
    .HYST (HYST)
  ) u_trig (
    .clk       (clk),
    .rst       (rst),
    .clear     (enter_flush),
    .sample_ok (in_wait && accept),
    .sample    (adc_data),
    .level     (trig_level),
    .trig_edge (trig_edge),
    .hit       (trig_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Dropping run overrides every other transition, including rearm.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (run) next_state = FLUSH;
      FLUSH:     if (flush_cnt == FLUSH_LAST) next_state = WAIT_TRIG;
      WAIT_TRIG: if (trig_event) next_state = last_word ? DONE : CAPTURE;
      CAPTURE:   if (last_word) next_state = DONE;
      DONE:      if (rearm) next_state = FLUSH;
      default:   next_state = IDLE;
    endcase
    if (!run) next_state = IDLE;
    enter_flush = (next_state == FLUSH) && (state != FLUSH);
    enter_done  = (next_state == DONE) && (state != DONE);
  end

  always_comb begin
    in_flush   = (state == FLUSH);
    in_wait    = (state == WAIT_TRIG);
    in_capture = (state == CAPTURE);
    sampling   = in_wait || in_capture;
    accept     = sampling && adc_valid && (dec_cnt == decim_q);
    trig_event = in_wait && accept && (trig_hit || (auto_en && (to_cnt >= AUTO_TO)));
    take_word  = (in_capture && accept) || trig_event;
    last_word  = take_word && (frame_cnt == LAST_WORD);
    write_ok   = take_word && run;
  end

  // A word dropped on fifo_full still counts toward the frame length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decim_q    <= '0;
      dec_cnt    <= '0;
      frame_cnt  <= '0;
      flush_cnt  <= '0;
      to_cnt     <= '0;
      fifo_we    <= 1'b0;
      fifo_di    <= '0;
      fifo_rst   <= 1'b1;
      frame_done <= 1'b0;
      auto_trig  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      fifo_rst   <= (next_state == FLUSH);
      frame_done <= enter_done;
      fifo_we    <= write_ok && !fifo_full;
      if (write_ok) fifo_di <= adc_data;
      if (enter_flush) begin
        decim_q   <= decim;
        dec_cnt   <= '0;
        frame_cnt <= '0;
        flush_cnt <= '0;
        to_cnt    <= '0;
        auto_trig <= 1'b0;
        ovf       <= 1'b0;
      end else begin
        if (in_flush) flush_cnt <= flush_cnt + 2'd1;
        if (in_wait && (to_cnt < AUTO_TO)) to_cnt <= to_cnt + 24'd1;
        if (sampling && adc_valid) dec_cnt <= accept ? '0 : dec_cnt + 16'd1;
        if (take_word) frame_cnt <= last_word ? '0 : frame_cnt + FCW'(1);
        if (trig_event) auto_trig <= !trig_hit;
        if (write_ok && fifo_full) ovf <= 1'b1;
      end
    end
  end

endmodule
